// File: rtl/i2s_capture_array.sv
// i2s_capture_array: multi-line I2S receiver with a one-frame buffer drained
// as a valid/ready stream (L0, R0, L1, R1, ...).
// Optional feature macro: I2S_CAP_ARRAY_SYNC_EN adds two-flop synchronisers on
// sck_i/ws_i/sd_i for external-master operation (+2 clk on every latency).
module i2s_capture_array #(
  parameter int unsigned N_LINES  = 2,
  parameter int unsigned SAMPLE_W = 24,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned N_CH    = 2 * N_LINES,
  localparam int unsigned CHAN_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sck_i,
  input  logic                ws_i,
  input  logic [N_LINES-1:0]  sd_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [SAMPLE_W-1:0] out_data_o,
  output logic [CHAN_W-1:0]   out_chan_o,
  output logic                out_last_o,
  output logic                overrun_o,
  output logic                frame_err_o,
  output logic [CNT_W-1:0]    ovf_cnt_o
);

  localparam int unsigned BIT_W = $clog2(SAMPLE_W + 1);

  typedef enum logic [1:0] {
    CAP_WAIT  = 2'd0,
    CAP_LEFT  = 2'd1,
    CAP_RIGHT = 2'd2
  } cap_state_e;

  typedef enum logic [1:0] {
    STR_IDLE = 2'd0,
    STR_LOAD = 2'd1,
    STR_SEND = 2'd2
  } str_state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic               sck_s;
  logic               ws_s;
  logic [N_LINES-1:0] sd_s;

`ifdef I2S_CAP_ARRAY_SYNC_EN
  logic [N_LINES+1:0] sync1_q;
  logic [N_LINES+1:0] sync2_q;

  // Two-flop synchronisers for an externally clocked I2S master.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sck_i, ws_i, sd_i};
      sync2_q <= sync1_q;
    end
  end

  assign {sck_s, ws_s, sd_s} = sync2_q;
`else
  assign sck_s = sck_i;
  assign ws_s  = ws_i;
  assign sd_s  = sd_i;
`endif

  // ---------------------------------------------------------------------------
  // Capture side
  // ---------------------------------------------------------------------------
  cap_state_e                        cap_q, cap_d;
  logic                              sck_q;
  logic                              ws_q, ws_d;
  logic [BIT_W-1:0]                  bit_cnt_q, bit_cnt_d;
  logic [N_LINES-1:0][SAMPLE_W-1:0]  shreg_q, shreg_d;
  logic [N_LINES-1:0][SAMPLE_W-1:0]  left_hold_q, left_hold_d;
  logic                              frame_done_q, frame_done_d;
  logic                              frame_err_q, frame_err_d;
  logic                              rise_c;
  logic                              slot_start_c;
  logic                              short_slot_c;

  assign rise_c       = sck_s & ~sck_q;
  assign slot_start_c = (ws_s != ws_q);
  assign short_slot_c = (cap_q != CAP_WAIT) && (bit_cnt_q != '0) &&
                        (bit_cnt_q < BIT_W'(SAMPLE_W));

  // Capture state and shift registers; everything advances only on SCK rise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_q        <= CAP_WAIT;
      sck_q        <= 1'b0;
      ws_q         <= 1'b1;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      left_hold_q  <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      cap_q        <= cap_d;
      sck_q        <= sck_s;
      ws_q         <= ws_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      left_hold_q  <= left_hold_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Slot tracking, MSB-first de-serialisation and short-slot detection.
  always_comb begin
    cap_d        = cap_q;
    ws_d         = ws_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    left_hold_d  = left_hold_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    if (rise_c) begin
      ws_d = ws_s;
      if (slot_start_c) begin
        // The bit sampled on the start event is the previous slot's LSB.
        bit_cnt_d = '0;
        if (short_slot_c) begin
          frame_err_d = 1'b1;
          cap_d       = ws_s ? CAP_WAIT : CAP_LEFT;
        end else if (!ws_s) begin
          cap_d = CAP_LEFT;
        end else if (cap_q == CAP_LEFT) begin
          cap_d = CAP_RIGHT;
        end
      end else if ((cap_q != CAP_WAIT) && (bit_cnt_q < BIT_W'(SAMPLE_W))) begin
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        for (int unsigned n = 0; n < N_LINES; n++) begin
          shreg_d[n] = {shreg_q[n][SAMPLE_W-2:0], sd_s[n]};
        end
        if (bit_cnt_q == BIT_W'(SAMPLE_W - 1)) begin
          if (cap_q == CAP_LEFT) begin
            left_hold_d = shreg_d;
          end else begin
            frame_done_d = 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame buffer and output stream
  // ---------------------------------------------------------------------------
  str_state_e                    str_q, str_d;
  logic [N_CH-1:0][SAMPLE_W-1:0] frame_q, frame_d;
  logic [CHAN_W-1:0]             chan_q, chan_d;
  logic                          out_valid_q, out_valid_d;
  logic [SAMPLE_W-1:0]           out_data_q, out_data_d;
  logic                          out_last_q, out_last_d;
  logic                          overrun_q, overrun_d;
  logic [CNT_W-1:0]              ovf_cnt_q, ovf_cnt_d;
  logic                          hs_c;
  logic                          last_c;
  logic                          free_c;
  logic [CHAN_W-1:0]             chan_nxt_c;

  assign hs_c       = out_valid_q & out_ready_i;
  assign last_c     = (chan_q == CHAN_W'(N_CH - 1));
  assign chan_nxt_c = chan_q + CHAN_W'(1);
  // A commit landing on the final handshake still finds the buffer free.
  assign free_c     = (str_q == STR_IDLE) || ((str_q == STR_SEND) && hs_c && last_c);

  // Stream state, frame buffer and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      str_q       <= STR_IDLE;
      frame_q     <= '0;
      chan_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      str_q       <= str_d;
      frame_q     <= frame_d;
      chan_q      <= chan_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      overrun_q   <= overrun_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  // Commit/overrun decision and channel-by-channel drain.
  always_comb begin
    str_d       = str_q;
    frame_d     = frame_q;
    chan_d      = chan_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    overrun_d   = 1'b0;
    ovf_cnt_d   = ovf_cnt_q;

    case (str_q)
      STR_LOAD: begin
        str_d       = STR_SEND;
        out_valid_d = 1'b1;
        chan_d      = '0;
        out_data_d  = frame_q[0];
        out_last_d  = 1'b0;
      end
      STR_SEND: begin
        if (hs_c) begin
          if (last_c) begin
            str_d       = STR_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            chan_d      = chan_nxt_c;
            out_data_d  = frame_q[chan_nxt_c];
            out_last_d  = (chan_nxt_c == CHAN_W'(N_CH - 1));
          end
        end
      end
      default: begin
        str_d = STR_IDLE;
      end
    endcase

    if (frame_done_q) begin
      if (free_c) begin
        for (int unsigned n = 0; n < N_LINES; n++) begin
          frame_d[2*n]   = left_hold_q[n];
          frame_d[2*n+1] = shreg_q[n];
        end
        str_d = STR_LOAD;
      end else begin
        overrun_d = 1'b1;
        if (ovf_cnt_q != {CNT_W{1'b1}}) begin
          ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_chan_o  = chan_q;
  assign out_last_o  = out_last_q;
  assign overrun_o   = overrun_q;
  assign frame_err_o = frame_err_q;
  assign ovf_cnt_o   = ovf_cnt_q;

endmodule

// File: tb/tb_i2s_capture_array.sv
// Scoreboard bench for i2s_capture_array: main instance (2 lines x 24 bit)
// plus a small instance (1 line x 8 bit, 4-bit counter) for counter saturation.
module tb_i2s_capture_array;

  localparam int unsigned NL = 2;
  localparam int unsigned SW = 24;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic          rst, sck, ws, ready;
  logic [NL-1:0] sd;
  logic          valid, last, ovr, ferr;
  logic [SW-1:0] data;
  logic [1:0]    chan;
  logic [CW-1:0] ovf;

  i2s_capture_array #(.N_LINES(NL), .SAMPLE_W(SW), .CNT_W(CW)) u_dut (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .ws_i(ws), .sd_i(sd),
    .out_valid_o(valid), .out_ready_i(ready), .out_data_o(data),
    .out_chan_o(chan), .out_last_o(last), .overrun_o(ovr),
    .frame_err_o(ferr), .ovf_cnt_o(ovf)
  );

  // saturation instance
  logic       rst2, sck2, ws2, v2, c2, l2, o2, e2;
  logic [0:0] sd2;
  logic [7:0] d2;
  logic [3:0] ovf2;

  i2s_capture_array #(.N_LINES(1), .SAMPLE_W(8), .CNT_W(4)) u_sat (
    .clk_i(clk), .rst_i(rst2), .sck_i(sck2), .ws_i(ws2), .sd_i(sd2),
    .out_valid_o(v2), .out_ready_i(1'b0), .out_data_o(d2),
    .out_chan_o(c2), .out_last_o(l2), .overrun_o(o2),
    .frame_err_o(e2), .ovf_cnt_o(ovf2)
  );

  int tests = 0;
  int fails = 0;
  int n_ovr = 0;
  int n_err = 0;
  int n_ovr2 = 0;
  bit sat_done = 1'b0;

  typedef struct packed {
    logic [SW-1:0] d;
    logic [1:0]    c;
    logic          l;
  } beat_t;

  beat_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [SW-1:0] l0, r0, l1, r1);
    exp_q.push_back('{d: l0, c: 2'd0, l: 1'b0});
    exp_q.push_back('{d: r0, c: 2'd1, l: 1'b0});
    exp_q.push_back('{d: l1, c: 2'd2, l: 1'b0});
    exp_q.push_back('{d: r1, c: 2'd3, l: 1'b1});
  endtask

  // Monitor: pulse counters and scoreboard compare on every handshake.
  always @(negedge clk) begin : mon
    beat_t e;
    if (ovr) n_ovr++;
    if (ferr) n_err++;
    if (o2) n_ovr2++;
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got data 0x%0h chan %0d, expected no beat", data, chan);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", 32'(data), 32'(e.d));
        check("beat_chan", 32'(chan), 32'(e.c));
        check("beat_last", 32'(last), 32'(e.l));
      end
    end
  end

  // One SCK period of 4 clk: data changes while SCK is low.
  task automatic sck_bit(input logic w, input logic [NL-1:0] d);
    @(negedge clk);
    sck = 1'b0; ws = w; sd = d;
    @(negedge clk);
    @(negedge clk);
    sck = 1'b1;
    @(negedge clk);
  endtask

  // Slot of len events; event 0 carries the previous LSB, events 1..SW the word.
  task automatic send_slot(input logic w, input logic [SW-1:0] a, input logic [SW-1:0] b,
                           input int len);
    logic [NL-1:0] d;
    for (int k = 0; k < len; k++) begin
      d = '0;
      if (k >= 1 && k <= int'(SW)) begin
        d[0] = a[SW-k];
        d[1] = b[SW-k];
      end
      sck_bit(w, d);
    end
  endtask

  task automatic send_frame(input logic [SW-1:0] l0, r0, l1, r1);
    send_slot(1'b0, l0, l1, 32);
    send_slot(1'b1, r0, r1, 32);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Saturation instance stimulus: 8-bit words in 16-event slots.
  task automatic sat_bit(input logic w, input logic d);
    @(negedge clk);
    sck2 = 1'b0; ws2 = w; sd2 = d;
    @(negedge clk);
    @(negedge clk);
    sck2 = 1'b1;
    @(negedge clk);
  endtask

  task automatic sat_frame(input logic [7:0] lw, input logic [7:0] rw);
    for (int k = 0; k < 16; k++) sat_bit(1'b0, (k >= 1 && k <= 8) ? lw[8-k] : 1'b0);
    for (int k = 0; k < 16; k++) sat_bit(1'b1, (k >= 1 && k <= 8) ? rw[8-k] : 1'b0);
  endtask

  initial begin : sat_proc
    rst2 = 1'b1; sck2 = 1'b0; ws2 = 1'b1; sd2 = '0;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    for (int f = 0; f < 20; f++) begin
      sat_frame((f == 0) ? 8'hA5 : 8'(f * 17), 8'h3C);
      if (f == 14) check("sat_cnt_14", 32'(ovf2), 32'd14);
      if (f == 15) check("sat_cnt_15", 32'(ovf2), 32'd15);
    end
    check("sat_cnt_final", 32'(ovf2), 32'd15);
    check("sat_pulses", 32'(n_ovr2), 32'd19);
    check("sat_held_valid", 32'(v2), 32'd1);
    check("sat_held_data", 32'(d2), 32'hA5);
    sat_done = 1'b1;
  end

  initial begin : main_proc
    int n;
    rst = 1'b1; sck = 1'b0; ws = 1'b1; sd = '0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_chan", 32'(chan), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_pulses", 32'({ovr, ferr}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // start inside a right slot: ignored until the first left start
    for (int k = 0; k < 10; k++) sck_bit(1'b1, NL'($urandom_range(0, 3)));
    push_frame(24'h7FFFFF, 24'h800000, 24'h123456, 24'hFEDCBA);
    send_frame(24'h7FFFFF, 24'h800000, 24'h123456, 24'hFEDCBA);
    wait_drain("drain_f1");
    check("no_err_on_sync", 32'(n_err), 32'd0);

    push_frame(24'h000001, 24'hFFFFFF, 24'h800001, 24'h0ABCDE);
    send_frame(24'h000001, 24'hFFFFFF, 24'h800001, 24'h0ABCDE);
    wait_drain("drain_f2");

    // overrun: second frame completes while first is still held
    @(posedge clk); #1 ready = 1'b0;
    push_frame(24'h5A5A5A, 24'hA5A5A5, 24'h00FF00, 24'hFF00FF);
    send_frame(24'h5A5A5A, 24'hA5A5A5, 24'h00FF00, 24'hFF00FF);
    send_frame(24'h111111, 24'h222222, 24'h333333, 24'h444444);
    check("ovr_pulses", 32'(n_ovr), 32'd1);
    check("ovr_cnt", 32'(ovf), 32'd1);
    check("held_valid", 32'(valid), 32'd1);
    check("held_data", 32'(data), 32'h5A5A5A);
    check("held_chan", 32'(chan), 32'd0);
    @(posedge clk); #1 ready = 1'b1;
    wait_drain("drain_f3");

    // short right slot: error, no output, next frame good
    send_slot(1'b0, 24'hDEAD01, 24'hDEAD02, 32);
    send_slot(1'b1, 24'hDEAD03, 24'hDEAD04, 13);
    push_frame(24'h13579B, 24'h2468AC, 24'h7FFFFE, 24'h800002);
    send_frame(24'h13579B, 24'h2468AC, 24'h7FFFFE, 24'h800002);
    wait_drain("drain_f5");
    check("err_pulses", 32'(n_err), 32'd1);

    // reset while sending channel 2
    @(posedge clk); #1 ready = 1'b0;
    exp_q.push_back('{d: 24'hC0FFEE, c: 2'd0, l: 1'b0});
    exp_q.push_back('{d: 24'hBADA55, c: 2'd1, l: 1'b0});
    send_frame(24'hC0FFEE, 24'hBADA55, 24'h0F0F0F, 24'hF0F0F0);
    n = 0;
    while (!valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("valid_before_rst", 32'(valid), 32'd1);
    @(posedge clk); #1 ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 ready = 1'b0;
    check("chan_before_rst", 32'(chan), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_valid", 32'(valid), 32'd0);
    check("rst_mid_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    ready = 1'b1;
    push_frame(24'h654321, 24'h9ABCDE, 24'h000010, 24'hFFFFF0);
    send_frame(24'h654321, 24'h9ABCDE, 24'h000010, 24'hFFFFF0);
    wait_drain("drain_f7");
    check("ovr_total", 32'(n_ovr), 32'd1);
    check("err_total", 32'(n_err), 32'd1);

    n = 0;
    while (!sat_done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("sat_finished", 32'(sat_done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_capture_array.md
# i2s_capture_array

Multi-line I2S receiver for the microphone array. Samples N_LINES serial data lines sharing one SCK/WS pair, de-serialises left and right words per line, and commits a complete frame of 2*N_LINES signed samples into a frame buffer. The frame is drained as a valid/ready stream, channel by channel, towards the DSP path and the VU meter. This block replaces the single-line 24-bit stereo capture and adds:
- parametrised line count and sample width;
- frame-level buffering with overrun detection;
- slot-length error detection.

## Interface
Parameters:
- N_LINES, 2, number of I2S data lines (each carries L+R), 1..8
- SAMPLE_W, 24, captured bits per slot, MSB-first, 8..32
- CNT_W, 16, width of saturating overrun counter

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- sck_i  in  1  I2S bit clock, sampled in clk_i domain
- ws_i  in  1  I2S word select (0 = left, 1 = right)
- sd_i  in  N_LINES  serial data, bit n = line n
- out_valid_o  out  1  stream sample valid
- out_ready_i  in  1  stream sample accepted when valid & ready
- out_data_o  out  SAMPLE_W  signed sample
- out_chan_o  out  $clog2(2*N_LINES) (min 1)  channel = 2*line + (right ? 1 : 0)
- out_last_o  out  1  high on last channel of frame
- overrun_o  out  1  one-cycle pulse, completed frame dropped
- frame_err_o  out  1  one-cycle pulse, slot shorter than SAMPLE_W bits
- ovf_cnt_o  out  CNT_W  saturating count of overruns

## Operation
- SCK edge detect: sck_q <= sck_i. Rising event when sck_i & ~sck_q. All capture logic advances only on rising events.
- On each rising event, sample ws and sd. ws_q holds ws from the previous event.
- Slot start: ws != ws_q.
  - The sd sampled on this same event is the previous slot's LSB. It is ignored.
  - bit_cnt <= 0.
- Following events: while bit_cnt < SAMPLE_W, shift sd[n] into shreg[n] MSB-first and increment bit_cnt. Bits beyond SAMPLE_W are ignored.
- When bit_cnt reaches SAMPLE_W:
  - left slot: copy shreg into left_hold[n];
  - right slot: raise the frame-complete strobe.
- Capture FSM:
  - WAIT_SYNC: after reset; ignores data until a left slot start (ws 1->0).
  - LEFT: on right slot start -> RIGHT.
  - RIGHT: on left slot start -> LEFT.
- Slot start arriving with 0 < bit_cnt < SAMPLE_W:
  - pulse frame_err_o;
  - discard the current frame (no commit);
  - go to WAIT_SYNC, unless the edge is itself a left start, in which case go to LEFT.
- Frame commit on right-word completion:
  - If the stream FSM is IDLE: copy left_hold[0..N-1] and right words into the frame buffer, then go to SEND with chan = 0.
  - Otherwise: drop the frame, pulse overrun_o, and increment ovf_cnt_o, saturating at 2^CNT_W-1. The buffer contents stay unchanged.
- Stream FSM:
  - IDLE: out_valid_o = 0.
  - SEND: out_valid_o = 1; out_data_o = buf[chan]. Order is L0, R0, L1, R1, ... out_last_o = (chan == 2*N_LINES-1).
  - On handshake: chan++. After the last channel -> IDLE.
  - out_data_o and out_chan_o hold stable while valid & ~ready.

## Timing
- Reset (rst_i high at a clk_i edge):
  - all outputs 0; out_valid_o = 0; ovf_cnt_o = 0;
  - FSMs go to WAIT_SYNC / IDLE; bit_cnt = 0; ws_q = 1.
- Reset mid-frame or mid-stream aborts both immediately. The buffered frame is lost.
- Rising-event detection costs 1 clk after the sck_i transition.
- Commit happens 1 clk after the rising event that captures the last right bit. out_valid_o asserts 1 clk later (2 clk after that event).
- With out_ready_i held high, one channel drains per clk; a frame takes 2*N_LINES clks.
- Commit and the final handshake in the same clk: the commit is treated as IDLE-available and is accepted, with no overrun. SEND restarts at chan 0 in the next clk.
- overrun_o and frame_err_o are single-clk pulses aligned to the commit/slot-start clk.
- SCK period must be ≥ 4 clk_i periods.

## Configuration
- I2S_CAP_ARRAY_SYNC_EN defined:
  - two-flop synchronisers on sck_i, ws_i and sd_i, for external-master (slave) operation;
  - every latency above increases by 2 clk;
  - SCK period must be ≥ 6 clk_i.
- Undefined: inputs are used directly. sck_i/ws_i must be generated in the clk_i domain (internal I2S clock generator).

## Test plan
- N_LINES=2, SAMPLE_W=24, 32-bit slots, out_ready_i=1. Frame L0=0x7FFFFF, R0=0x800000, L1=0x123456, R1=0xFEDCBA -> four beats, chan 0..3, those values, out_last_o only on chan 3.
- Start stimulus mid right slot after reset -> no output until first complete L/R frame after a ws 1->0 edge.
- out_ready_i=0 across two frame completions -> first frame held intact, one overrun_o pulse, ovf_cnt_o=1. Release ready -> original four values drained.
- Shorten a right slot to 12 bits -> frame_err_o pulses, no output for that frame. The next full frame is captured correctly.
- Assert rst_i during SEND at chan 2 -> out_valid_o=0 next clk, ovf_cnt_o=0. Resync on next left start.
- Force 2^CNT_W+3 overruns -> ovf_cnt_o saturates at 0xFFFF (CNT_W=16).
